// File: rtl/fifo32_buffer_if.sv
// Producer/consumer handshake bundle for fifo32_buffer.
// The master modport is the producer/consumer side. The slave modport is the FIFO itself.
interface fifo32_buffer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] din;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] dout;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH:0]   data_count;
  logic                  wr_ack;
  logic                  wr_err;
  logic                  rd_ack;
  logic                  rd_err;
  logic                  almost_full;
  logic                  almost_empty;

  modport master (
    output wr_en, din, rd_en,
    input  dout, full, empty, data_count, wr_ack, wr_err, rd_ack, rd_err,
           almost_full, almost_empty
  );

  modport slave (
    input  wr_en, din, rd_en,
    output dout, full, empty, data_count, wr_ack, wr_err, rd_ack, rd_err,
           almost_full, almost_empty
  );
endinterface

// File: rtl/fifo32_buffer.sv
// 8x32 synchronous FIFO with registered status, ack/err pulses and 1-cycle read latency.
// Optional almost_full/almost_empty flags are enabled by defining FIFO_ALMOST_FLAGS_EN.
module fifo32_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic             i_clk,
  input  logic             i_reset,
  fifo32_buffer_if.slave   bus
);
  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH:0]   LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   LP_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   LP_ZERO  = (ADDR_WIDTH+1)'(0);
  localparam logic [ADDR_WIDTH-1:0] LP_PINC  = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [ADDR_WIDTH:0]   w_count_next;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_wr_ack;
  logic                  r_wr_err;
  logic                  r_rd_ack;
  logic                  r_rd_err;
  logic                  w_wr_acc;
  logic                  w_rd_acc;

  // Accept decisions, next count and next FSM state
  always_comb begin
    w_wr_acc     = bus.wr_en && ((r_state != ST_FULL) || bus.rd_en);
    w_rd_acc     = bus.rd_en && (r_state != ST_EMPTY);
    w_count_next = r_count;
    w_state_next = r_state;
    if (w_wr_acc && !w_rd_acc) begin
      w_count_next = r_count + LP_ONE;
    end else if (w_rd_acc && !w_wr_acc) begin
      w_count_next = r_count - LP_ONE;
    end else begin
      w_count_next = r_count;
    end
    case (r_state)
      ST_EMPTY: begin
        if (w_wr_acc) w_state_next = ST_PARTIAL;
        else          w_state_next = ST_EMPTY;
      end
      ST_PARTIAL: begin
        if (w_count_next == LP_DEPTH)     w_state_next = ST_FULL;
        else if (w_count_next == LP_ZERO) w_state_next = ST_EMPTY;
        else                              w_state_next = ST_PARTIAL;
      end
      ST_FULL: begin
        if (w_rd_acc && !w_wr_acc) w_state_next = ST_PARTIAL;
        else                       w_state_next = ST_FULL;
      end
      default: w_state_next = ST_EMPTY;
    endcase
  end

  // State, pointers, count, read data and handshake pulses
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= ST_EMPTY;
      r_wr_ptr <= {ADDR_WIDTH{1'b0}};
      r_rd_ptr <= {ADDR_WIDTH{1'b0}};
      r_count  <= LP_ZERO;
      r_dout   <= {DATA_WIDTH{1'b0}};
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_wr_ack <= 1'b0;
      r_wr_err <= 1'b0;
      r_rd_ack <= 1'b0;
      r_rd_err <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_count  <= w_count_next;
      r_full   <= (w_state_next == ST_FULL);
      r_empty  <= (w_state_next == ST_EMPTY);
      r_wr_ack <= w_wr_acc;
      r_wr_err <= bus.wr_en && !w_wr_acc;
      r_rd_ack <= w_rd_acc;
      r_rd_err <= bus.rd_en && !w_rd_acc;
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + LP_PINC;
      if (w_rd_acc) begin
        // Non-blocking read sees the old word even when a full-state write hits the same slot
        r_dout   <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + LP_PINC;
      end
    end
  end

  // Storage array, no reset needed since dout is only loaded from written slots
  always_ff @(posedge i_clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= bus.din;
  end

`ifdef FIFO_ALMOST_FLAGS_EN
  logic r_almost_full;
  logic r_almost_empty;

  // Almost flags track the next count so they move with data_count
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b0;
    end else begin
      r_almost_full  <= (w_count_next == (LP_DEPTH - LP_ONE));
      r_almost_empty <= (w_count_next == LP_ONE);
    end
  end

  assign bus.almost_full  = r_almost_full;
  assign bus.almost_empty = r_almost_empty;
`else
  assign bus.almost_full  = 1'b0;
  assign bus.almost_empty = 1'b0;
`endif

  assign bus.dout       = r_dout;
  assign bus.full       = r_full;
  assign bus.empty      = r_empty;
  assign bus.data_count = r_count;
  assign bus.wr_ack     = r_wr_ack;
  assign bus.wr_err     = r_wr_err;
  assign bus.rd_ack     = r_rd_ack;
  assign bus.rd_err     = r_rd_err;
endmodule

// File: tb/tb_fifo32_buffer.sv
// Directed testbench for fifo32_buffer; expected values are hand-derived per scenario.
module tb_fifo32_buffer;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

`ifdef FIFO_ALMOST_FLAGS_EN
  localparam bit ALMOST_EN = 1'b1;
`else
  localparam bit ALMOST_EN = 1'b0;
`endif

  fifo32_buffer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(3)) bus ();

  fifo32_buffer #(.DATA_WIDTH(32), .DEPTH(8), .ADDR_WIDTH(3)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.din   = 32'h0;
    rst       = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if (bus.empty !== 1'b1) begin
      n_errors++; $display("FAIL reset_empty: got %b expected 1", bus.empty);
    end
    n_checks++;
    if (bus.full !== 1'b0) begin
      n_errors++; $display("FAIL reset_full: got %b expected 0", bus.full);
    end
    n_checks++;
    if (bus.data_count !== 4'd0) begin
      n_errors++; $display("FAIL reset_count: got %0d expected 0", bus.data_count);
    end
    n_checks++;
    if (bus.dout !== 32'h0) begin
      n_errors++; $display("FAIL reset_dout: got %h expected 00000000", bus.dout);
    end
    n_checks++;
    if ({bus.wr_ack, bus.wr_err, bus.rd_ack, bus.rd_err} !== 4'b0000) begin
      n_errors++; $display("FAIL reset_pulses: got %b expected 0000",
                           {bus.wr_ack, bus.wr_err, bus.rd_ack, bus.rd_err});
    end
    n_checks++;
    if ({bus.almost_full, bus.almost_empty} !== 2'b00) begin
      n_errors++; $display("FAIL reset_almost: got %b expected 00",
                           {bus.almost_full, bus.almost_empty});
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      bus.wr_en = 1'b1;
      bus.din   = 32'(i);
      tick();
      n_checks++;
      if (bus.wr_ack !== 1'b1 || bus.data_count !== 4'(i)) begin
        n_errors++; $display("FAIL fill_ack_count[%0d]: got ack=%b count=%0d expected ack=1 count=%0d",
                             i, bus.wr_ack, bus.data_count, i);
      end
      n_checks++;
      if (bus.almost_full !== (ALMOST_EN && i == 7) || bus.almost_empty !== (ALMOST_EN && i == 1)) begin
        n_errors++; $display("FAIL fill_almost[%0d]: got af=%b ae=%b expected af=%b ae=%b", i,
                             bus.almost_full, bus.almost_empty, ALMOST_EN && i == 7, ALMOST_EN && i == 1);
      end
    end
    n_checks++;
    if (bus.full !== 1'b1 || bus.empty !== 1'b0) begin
      n_errors++; $display("FAIL fill_flags: got full=%b empty=%b expected full=1 empty=0", bus.full, bus.empty);
    end
    bus.din = 32'hDEADBEEF;
    tick();
    bus.wr_en = 1'b0;
    n_checks++;
    if (bus.wr_err !== 1'b1 || bus.wr_ack !== 1'b0 || bus.data_count !== 4'd8 || bus.full !== 1'b1) begin
      n_errors++; $display("FAIL overflow: got err=%b ack=%b count=%0d full=%b expected err=1 ack=0 count=8 full=1",
                           bus.wr_err, bus.wr_ack, bus.data_count, bus.full);
    end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 8; i++) begin
      bus.rd_en = 1'b1;
      tick();
      n_checks++;
      if (bus.rd_ack !== 1'b1 || bus.dout !== 32'(i) || bus.data_count !== 4'(8 - i)) begin
        n_errors++; $display("FAIL drain[%0d]: got ack=%b dout=%h count=%0d expected ack=1 dout=%h count=%0d",
                             i, bus.rd_ack, bus.dout, bus.data_count, 32'(i), 8 - i);
      end
      n_checks++;
      if (bus.almost_full !== (ALMOST_EN && i == 1) || bus.almost_empty !== (ALMOST_EN && i == 7)) begin
        n_errors++; $display("FAIL drain_almost[%0d]: got af=%b ae=%b expected af=%b ae=%b", i,
                             bus.almost_full, bus.almost_empty, ALMOST_EN && i == 1, ALMOST_EN && i == 7);
      end
    end
    n_checks++;
    if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin
      n_errors++; $display("FAIL drain_flags: got empty=%b full=%b expected empty=1 full=0", bus.empty, bus.full);
    end
    tick();
    bus.rd_en = 1'b0;
    n_checks++;
    if (bus.rd_err !== 1'b1 || bus.rd_ack !== 1'b0 || bus.dout !== 32'h8 || bus.data_count !== 4'd0) begin
      n_errors++; $display("FAIL underflow: got err=%b ack=%b dout=%h count=%0d expected err=1 ack=0 dout=00000008 count=0",
                           bus.rd_err, bus.rd_ack, bus.dout, bus.data_count);
    end
    tick();
    n_checks++;
    if ({bus.wr_ack, bus.wr_err, bus.rd_ack, bus.rd_err} !== 4'b0000 || bus.dout !== 32'h8) begin
      n_errors++; $display("FAIL idle_hold: got pulses=%b dout=%h expected pulses=0000 dout=00000008",
                           {bus.wr_ack, bus.wr_err, bus.rd_ack, bus.rd_err}, bus.dout);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 5; i++) begin
      bus.wr_en = 1'b1;
      bus.din   = 32'h50 + 32'(i);
      tick();
    end
    bus.wr_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.rd_en = 1'b1;
      tick();
      n_checks++;
      if (bus.dout !== 32'h50 + 32'(i)) begin
        n_errors++; $display("FAIL wrap_pre[%0d]: got %h expected %h", i, bus.dout, 32'h50 + 32'(i));
      end
    end
    bus.rd_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.wr_en = 1'b1;
      bus.din   = 32'hA0000000 + 32'(i);
      tick();
    end
    bus.wr_en = 1'b0;
    n_checks++;
    if (bus.full !== 1'b1 || bus.data_count !== 4'd8) begin
      n_errors++; $display("FAIL wrap_full: got full=%b count=%0d expected full=1 count=8", bus.full, bus.data_count);
    end
    for (int i = 0; i < 8; i++) begin
      bus.rd_en = 1'b1;
      tick();
      n_checks++;
      if (bus.dout !== 32'hA0000000 + 32'(i) || bus.rd_ack !== 1'b1) begin
        n_errors++; $display("FAIL wrap_read[%0d]: got dout=%h ack=%b expected dout=%h ack=1",
                             i, bus.dout, bus.rd_ack, 32'hA0000000 + 32'(i));
      end
    end
    bus.rd_en = 1'b0;
    n_checks++;
    if (bus.data_count !== 4'd0 || bus.empty !== 1'b1) begin
      n_errors++; $display("FAIL wrap_end: got count=%0d empty=%b expected count=0 empty=1", bus.data_count, bus.empty);
    end
  endtask

  task automatic test_simultaneous();
    bus.wr_en = 1'b1;
    bus.rd_en = 1'b1;
    bus.din   = 32'h12345678;
    tick();
    bus.rd_en = 1'b0;
    n_checks++;
    if (bus.rd_err !== 1'b1 || bus.rd_ack !== 1'b0 || bus.wr_ack !== 1'b1 ||
        bus.data_count !== 4'd1 || bus.empty !== 1'b0) begin
      n_errors++; $display("FAIL simul_empty: got rd_err=%b rd_ack=%b wr_ack=%b count=%0d empty=%b expected 1 0 1 1 0",
                           bus.rd_err, bus.rd_ack, bus.wr_ack, bus.data_count, bus.empty);
    end
    for (int i = 0; i < 7; i++) begin
      bus.din = 32'hB0000000 + 32'(i);
      tick();
    end
    n_checks++;
    if (bus.full !== 1'b1 || bus.data_count !== 4'd8) begin
      n_errors++; $display("FAIL simul_prefill: got full=%b count=%0d expected full=1 count=8", bus.full, bus.data_count);
    end
    bus.rd_en = 1'b1;
    bus.din   = 32'hCAFEF00D;
    tick();
    bus.wr_en = 1'b0;
    n_checks++;
    if (bus.dout !== 32'h12345678 || bus.rd_ack !== 1'b1 || bus.wr_ack !== 1'b1 ||
        bus.wr_err !== 1'b0 || bus.data_count !== 4'd8 || bus.full !== 1'b1) begin
      n_errors++; $display("FAIL simul_full: got dout=%h rd_ack=%b wr_ack=%b wr_err=%b count=%0d full=%b expected 12345678 1 1 0 8 1",
                           bus.dout, bus.rd_ack, bus.wr_ack, bus.wr_err, bus.data_count, bus.full);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if (bus.dout !== ((i < 7) ? 32'hB0000000 + 32'(i) : 32'hCAFEF00D)) begin
        n_errors++; $display("FAIL simul_drain[%0d]: got %h expected %h", i, bus.dout,
                             (i < 7) ? 32'hB0000000 + 32'(i) : 32'hCAFEF00D);
      end
    end
    bus.rd_en = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    bus.wr_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.din = 32'hC0 + 32'(i);
      tick();
    end
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    n_checks++;
    if (bus.data_count !== 4'd5 || bus.dout !== 32'hC0 || bus.rd_ack !== 1'b1) begin
      n_errors++; $display("FAIL mid_setup: got count=%0d dout=%h ack=%b expected count=5 dout=000000c0 ack=1",
                           bus.data_count, bus.dout, bus.rd_ack);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.data_count !== 4'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0 ||
        bus.dout !== 32'h0 || bus.rd_ack !== 1'b0) begin
      n_errors++; $display("FAIL mid_async: got count=%0d empty=%b full=%b dout=%h rd_ack=%b expected 0 1 0 00000000 0",
                           bus.data_count, bus.empty, bus.full, bus.dout, bus.rd_ack);
    end
    tick();
    rst = 1'b0;
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    n_checks++;
    if (bus.rd_err !== 1'b1 || bus.rd_ack !== 1'b0 || bus.dout !== 32'h0 || bus.data_count !== 4'd0) begin
      n_errors++; $display("FAIL mid_post_read: got err=%b ack=%b dout=%h count=%0d expected 1 0 00000000 0",
                           bus.rd_err, bus.rd_ack, bus.dout, bus.data_count);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/fifo32_buffer.md
Name: fifo32_buffer

Overview:
- 8-entry × 32-bit synchronous FIFO with separate write (producer) and read (consumer) handshakes.
- Provides the consumer-side read path for 32-bit words, so a stored value can be queued and drained in order rather than overwritten every clock.
- Sits between a 32-bit data producer and a consumer.
- Reports full/empty/count status and per-request ack/error pulses.

Parameters:
- DATA_WIDTH, 32, word width in bits.
- DEPTH, 8, number of entries; must be a power of two.
- ADDR_WIDTH, 3, log2(DEPTH); width of the read/write pointers.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- wr_en  input  1  write request; sampled on the rising edge of clk.
- din  input  DATA_WIDTH  write data; captured with wr_en.
- rd_en  input  1  read request; sampled on the rising edge of clk.
- dout  output  DATA_WIDTH  read data, registered.
- full  output  1  high when count == DEPTH.
- empty  output  1  high when count == 0.
- data_count  output  ADDR_WIDTH+1  number of stored entries, 0..DEPTH.
- wr_ack  output  1  one-cycle pulse: the write was accepted.
- wr_err  output  1  one-cycle pulse: the write was rejected because the FIFO was full.
- rd_ack  output  1  one-cycle pulse: dout holds a new valid word.
- rd_err  output  1  one-cycle pulse: the read was rejected because the FIFO was empty.
- almost_full  output  1  see Optional Feature.
- almost_empty  output  1  see Optional Feature.

Behaviour:
- Reset:
  - Asserting reset at any time, including mid-transfer, immediately clears wr_ptr, rd_ptr, data_count, dout, wr_ack, wr_err, rd_ack, rd_err, almost_full and almost_empty to 0.
  - It sets empty=1, full=0 and state=EMPTY.
  - Storage array contents are don't-care after reset and must never be observable on dout.
- State machine, updated on the clk edge from the next count:
  - EMPTY (count=0), PARTIAL (0<count<DEPTH), FULL (count=DEPTH).
  - EMPTY → PARTIAL on an accepted write.
  - PARTIAL → FULL when a write-only takes count to DEPTH.
  - PARTIAL → EMPTY when a read-only takes count to 0.
  - FULL → PARTIAL on an accepted read-only.
  - A simultaneous accepted read and write leaves the state unchanged.
- Outputs from state: full = (state==FULL); empty = (state==EMPTY). Both are registered and change in the same cycle as data_count.
- Write rules:
  - A write is accepted if wr_en=1 and (state≠FULL, or rd_en=1 in the same cycle).
  - On accept: mem[wr_ptr] <= din; wr_ptr increments modulo DEPTH; wr_ack=1 next cycle.
  - wr_en=1 while FULL with rd_en=0: no storage change, wr_err=1 next cycle.
- Read rules:
  - A read is accepted if rd_en=1 and state≠EMPTY.
  - On accept: dout <= mem[rd_ptr]; rd_ptr increments modulo DEPTH; rd_ack=1 next cycle.
  - Read latency is 1 clock from the rd_en sample edge to valid dout.
  - rd_en=1 while EMPTY: dout holds its previous value, rd_err=1 next cycle. There is no write-to-read bypass.
- Simultaneous rd_en and wr_en:
  - EMPTY: the write is accepted and the read errors; count becomes 1.
  - PARTIAL: both are accepted; count is unchanged.
  - FULL: both are accepted; the read returns the oldest word, the write fills the freed slot, and count stays at DEPTH.
- data_count increments on a write-only accept, decrements on a read-only accept, and is unchanged otherwise. It never exceeds DEPTH or underflows.
- Pointers wrap from DEPTH-1 to 0 with no other side effect.
- dout holds its value when no read is accepted.
- The ack/err pulses are single-cycle and are 0 in any cycle with no corresponding request.

Optional Feature:
- Macro: FIFO_ALMOST_FLAGS_EN.
- Defined:
  - almost_full is registered and high when count == DEPTH-1.
  - almost_empty is registered and high when count == 1.
  - Both follow data_count in the same cycle.
- Undefined: almost_full and almost_empty are tied to 0, and no extra flops are inferred.

Test Plan:
- Reset then idle → empty=1, full=0, data_count=0, dout=0x00000000, all ack/err=0.
- Write 0x00000001..0x00000008 on 8 consecutive cycles → wr_ack each cycle, then data_count=8, full=1, empty=0. A 9th write of 0xDEADBEEF → wr_err=1, count stays 8.
- Read 8 times after the fill → dout=0x00000001..0x00000008 in order, one cycle after each rd_en, rd_ack each cycle. Ends with empty=1. A 9th read → rd_err=1, dout stays 0x00000008.
- Wrap-around: write 5, read 5, then write 0xA0000000..0xA0000007 and read 8 → order preserved across pointer wrap, count returns to 0.
- Simultaneous events:
  - Empty with rd_en=wr_en=1, din=0x12345678 → rd_err=1, wr_ack=1, count=1.
  - Full with both asserted → oldest word on dout, count stays 8, full stays 1.
- Reset mid-operation: assert reset asynchronously with count=5 → outputs clear immediately, before the next clk edge. After release, a read → rd_err=1.
- (With FIFO_ALMOST_FLAGS_EN) count=7 → almost_full=1; count=1 → almost_empty=1.
